// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution scan controller: controller states
// and kernel geometry constants.
package conv_pkg;

    // Kernel edge length and number of taps per window.
    localparam int K    = 3;
    localparam int TAPS = K * K;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage : conv_pkg

// File: rtl/conv_addr_gen.sv
// Window/tap counters for a valid-only 3x3 scan. Produces the row-major pixel
// address and the kernel tap index using incremental adders only.
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              adv,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        coef_idx,
    output logic [15:0]       win_row,
    output logic [15:0]       win_col,
    output logic              last_tap
);

    // Step from the last tap of one kernel row to the first tap of the next.
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W - (K - 1));
    // Step of the window base from the last column of a row to the next row.
    localparam logic [ADDR_W-1:0] WRAP_STEP = ADDR_W'(K);
    localparam logic [15:0]       LAST_C    = 16'(IMG_W - K);
    localparam logic [15:0]       LAST_R    = 16'(IMG_H - K);
    localparam logic [1:0]        KX_LAST   = 2'(K - 1);
    localparam logic [3:0]        TAP_LAST  = 4'(TAPS - 1);

    logic [3:0]        tap_reg,  tap_next;
    logic [1:0]        kx_reg,   kx_next;
    logic [15:0]       row_reg,  row_next;
    logic [15:0]       col_reg,  col_next;
    logic [ADDR_W-1:0] base_reg, base_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;

    // Advance tap, then column, then row; the window base tracks r*IMG_W+c.
    always_comb begin
        tap_next  = tap_reg;
        kx_next   = kx_reg;
        row_next  = row_reg;
        col_next  = col_reg;
        base_next = base_reg;
        addr_next = addr_reg;
        if (clr) begin
            tap_next  = '0;
            kx_next   = '0;
            row_next  = '0;
            col_next  = '0;
            base_next = '0;
            addr_next = '0;
        end else if (adv) begin
            if (kx_reg != KX_LAST) begin
                kx_next   = kx_reg + 2'd1;
                tap_next  = tap_reg + 4'd1;
                addr_next = addr_reg + 1'b1;
            end else if (tap_reg != TAP_LAST) begin
                kx_next   = '0;
                tap_next  = tap_reg + 4'd1;
                addr_next = addr_reg + ROW_STEP;
            end else begin
                kx_next  = '0;
                tap_next = '0;
                if (col_reg != LAST_C) begin
                    col_next  = col_reg + 16'd1;
                    base_next = base_reg + 1'b1;
                    addr_next = base_reg + 1'b1;
                end else if (row_reg != LAST_R) begin
                    col_next  = '0;
                    row_next  = row_reg + 16'd1;
                    base_next = base_reg + WRAP_STEP;
                    addr_next = base_reg + WRAP_STEP;
                end else begin
                    col_next  = '0;
                    row_next  = '0;
                    base_next = '0;
                    addr_next = '0;
                end
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_reg  <= '0;
            kx_reg   <= '0;
            row_reg  <= '0;
            col_reg  <= '0;
            base_reg <= '0;
            addr_reg <= '0;
        end else begin
            tap_reg  <= tap_next;
            kx_reg   <= kx_next;
            row_reg  <= row_next;
            col_reg  <= col_next;
            base_reg <= base_next;
            addr_reg <= addr_next;
        end
    end

    assign mem_addr = addr_reg;
    assign coef_idx = tap_reg;
    assign win_row  = row_reg;
    assign win_col  = col_reg;
    assign last_tap = (tap_reg == TAP_LAST) && (row_reg == LAST_R) && (col_reg == LAST_C);

endmodule : conv_addr_gen

// File: rtl/conv_scan_ctrl.sv
// 3x3 valid-convolution scan controller: frame FSM, read issue, MAC strobe
// alignment to the 1-cycle RAM latency, and output pixel / frame-end strobes.
module conv_scan_ctrl
    import conv_pkg::*;
#(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    output logic              rdy,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        coef_idx,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              done,
    output logic [15:0]       out_row,
    output logic [15:0]       out_col,
    output logic              frame_done
);

    // Parameter sanity checks at elaboration.
    if (IMG_W < K || IMG_H < K) begin : g_bad_size
        $error("conv_scan_ctrl: IMG_W and IMG_H must be at least 3");
    end
    if (ADDR_W < $clog2(IMG_W * IMG_H)) begin : g_bad_addr_w
        $error("conv_scan_ctrl: ADDR_W too narrow for IMG_W*IMG_H");
    end

    state_t state_reg, state_next;

    logic        issue;
    logic        last_tap;
    logic [15:0] win_row, win_col;

    // Tap-issue stage (aligned with read data returning from RAM).
    logic        mac_en_reg, mac_clr_reg, tap_end_reg, last_win_reg;
    logic [15:0] row_s1_reg, col_s1_reg;
    // Output stage.
    logic        done_reg, frame_done_reg;
    logic [15:0] out_row_reg, out_col_reg;

    // One tap is issued every cycle spent in RUN, so reads are back-to-back.
    assign issue = (state_reg == RUN);

    conv_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .clr      (state_reg == IDLE),
        .adv      (issue),
        .mem_addr (mem_addr),
        .coef_idx (coef_idx),
        .win_row  (win_row),
        .win_col  (win_col),
        .last_tap (last_tap)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: go only matters in IDLE; DRAIN waits for the final done.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (go)             state_next = RUN;
            RUN:     if (last_tap)       state_next = DRAIN;
            DRAIN:   if (frame_done_reg) state_next = IDLE;
            default:                     state_next = IDLE;
        endcase
    end

    // MAC/done alignment pipeline: stage 1 follows the read by one cycle, stage 2 by two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mac_en_reg     <= 1'b0;
            mac_clr_reg    <= 1'b0;
            tap_end_reg    <= 1'b0;
            last_win_reg   <= 1'b0;
            row_s1_reg     <= '0;
            col_s1_reg     <= '0;
            done_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
            out_row_reg    <= '0;
            out_col_reg    <= '0;
        end else begin
            mac_en_reg     <= issue;
            mac_clr_reg    <= issue && (coef_idx == 4'd0);
            tap_end_reg    <= issue && (coef_idx == 4'(TAPS - 1));
            last_win_reg   <= issue && last_tap;
            if (issue) begin
                row_s1_reg <= win_row;
                col_s1_reg <= win_col;
            end
            done_reg       <= tap_end_reg;
            frame_done_reg <= last_win_reg;
            if (tap_end_reg) begin
                out_row_reg <= row_s1_reg;
                out_col_reg <= col_s1_reg;
            end
        end
    end

    assign rdy        = (state_reg == IDLE);
    assign mem_rd     = issue;
    assign mac_en     = mac_en_reg;
    assign mac_clr    = mac_clr_reg;
    assign done       = done_reg;
    assign frame_done = frame_done_reg;
    assign out_row    = out_row_reg;
    assign out_col    = out_col_reg;

endmodule : conv_scan_ctrl

// File: tb/tb_conv_scan_ctrl.sv
// Self-checking bench for conv_scan_ctrl on a 5x4 image (6 windows, 54 reads).
// Expected per-cycle outputs of a frame come from window/tap arithmetic.
module tb_conv_scan_ctrl;

    localparam int W    = 5;
    localparam int H    = 4;
    localparam int AW   = 5;
    localparam int OW   = W - 2;          // output columns
    localparam int NW   = (W - 2) * (H - 2);
    localparam int NR   = NW * 9;         // reads per frame
    localparam int LEN  = NR + 3;         // cycles from go edge until rdy returns

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          go  = 1'b0;
    logic          rdy, mem_rd, mac_clr, mac_en, done, frame_done;
    logic [AW-1:0] mem_addr;
    logic [3:0]    coef_idx;
    logic [15:0]   out_row, out_col;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct packed {
        logic          go;        // input applied after this cycle's check
        logic          rdy;
        logic          mem_rd;
        logic [AW-1:0] addr;
        logic [3:0]    coef;
        logic          mac_en;
        logic          mac_clr;
        logic          done;
        logic [15:0]   row;
        logic [15:0]   col;
        logic          frame_done;
        logic          chk_addr;  // compare addr/coef even without mem_rd
        logic          chk_rc;    // compare row/col even without done
    } vec_t;

    vec_t tbl [1:LEN];
    vec_t rst_vec;
    vec_t idle_vec;

    conv_scan_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .go         (go),
        .rdy        (rdy),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .coef_idx   (coef_idx),
        .mac_clr    (mac_clr),
        .mac_en     (mac_en),
        .done       (done),
        .out_row    (out_row),
        .out_col    (out_col),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Expected outputs j cycles after the go-sampling edge (j=1 is the first read).
    function automatic vec_t exp_at(int j);
        vec_t v;
        int n, t, r, c;
        v = '0;
        v.rdy = (j == LEN);
        if (j >= 1 && j <= NR) begin
            n = (j - 1) / 9;
            t = (j - 1) % 9;
            r = n / OW;
            c = n % OW;
            v.mem_rd = 1'b1;
            v.addr   = AW'((r + t / 3) * W + c + t % 3);
            v.coef   = 4'(t);
        end
        if (j >= 2 && j <= NR + 1) begin
            v.mac_en  = 1'b1;
            v.mac_clr = ((j - 2) % 9 == 0);
        end
        if (j >= 11 && j <= NR + 2 && (j - 11) % 9 == 0) begin
            n = (j - 11) / 9;
            v.done       = 1'b1;
            v.row        = 16'(n / OW);
            v.col        = 16'(n % OW);
            v.frame_done = (n == NW - 1);
        end
        return v;
    endfunction

    task automatic check(input string name, input int j, input vec_t e);
        logic bad;
        n_vec++;
        bad = (rdy != e.rdy) || (mem_rd != e.mem_rd) || (mac_en != e.mac_en) ||
              (mac_clr != e.mac_clr) || (done != e.done) || (frame_done != e.frame_done);
        if ((e.mem_rd || e.chk_addr) && (mem_addr != e.addr || coef_idx != e.coef)) bad = 1'b1;
        if ((e.done || e.chk_rc) && (out_row != e.row || out_col != e.col)) bad = 1'b1;
        if (bad) begin
            n_miss++;
            $display("FAIL %s[%0d]: got rdy=%0b rd=%0b addr=%0d coef=%0d en=%0b clr=%0b done=%0b rc=(%0d,%0d) fd=%0b; want rdy=%0b rd=%0b addr=%0d coef=%0d en=%0b clr=%0b done=%0b rc=(%0d,%0d) fd=%0b",
                     name, j, rdy, mem_rd, mem_addr, coef_idx, mac_en, mac_clr, done, out_row, out_col, frame_done,
                     e.rdy, e.mem_rd, e.addr, e.coef, e.mac_en, e.mac_clr, e.done, e.row, e.col, e.frame_done);
        end
    endtask

    // Runs one frame from the go-sampling edge (caller leaves go=1 while in IDLE).
    // noise: random go during RUN/DRAIN; hold: keep go high throughout;
    // rst_at: pulse reset in that cycle and stop (0 = never).
    task automatic run_frame(input string name, input bit noise, input bit hold, input int rst_at);
        for (int j = 1; j <= LEN; j++) begin
            @(posedge clk);
            #1;
            if (j == rst_at) begin
                rst = 1'b1;
                #1;
                check({name, "_rst"}, j, rst_vec);
                return;
            end
            check(name, j, tbl[j]);
            if (hold)                  go = 1'b1;
            else if (noise && j < LEN) go = 1'($urandom % 2);
            else                       go = tbl[j].go;
        end
    endtask

    task automatic idle_cycles(input string name, input int n, input vec_t e);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check(name, i, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int j = 1; j <= LEN; j++) tbl[j] = exp_at(j);
        rst_vec          = '0;
        rst_vec.rdy      = 1'b1;
        rst_vec.chk_addr = 1'b1;
        rst_vec.chk_rc   = 1'b1;
        idle_vec         = '0;
        idle_vec.rdy     = 1'b1;

        // Reset state, then no activity without go.
        rst = 1'b1;
        go  = 1'b0;
        idle_cycles("reset_hold", 3, rst_vec);
        rst = 1'b0;
        idle_cycles("after_reset", 3, rst_vec);

        // Clean full frame.
        go = 1'b1;
        run_frame("frame_clean", 1'b0, 1'b0, 0);

        // Frames with go toggling randomly while busy and random idle gaps.
        for (int f = 0; f < 4; f++) begin
            idle_cycles("gap", int'($urandom_range(0, 4)), idle_vec);
            go = 1'b1;
            run_frame("frame_busy_go", 1'b1, 1'b0, 0);
        end

        // Reset in the middle of a frame, then a fresh go restarts from address 0.
        go = 1'b1;
        run_frame("frame_mid", 1'b0, 1'b0, 30);
        go = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycles("post_mid_reset", 3, rst_vec);
        go = 1'b1;
        run_frame("frame_restart", 1'b0, 1'b0, 0);

        // Back-to-back frames with go held high.
        go = 1'b1;
        run_frame("b2b_first", 1'b0, 1'b1, 0);
        run_frame("b2b_second", 1'b0, 1'b0, 0);
        idle_cycles("final_idle", 2, idle_vec);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_conv_scan_ctrl

// File: doc/conv_scan_ctrl.md
CONV_SCAN_CTRL -- requirements
Module: conv_scan_ctrl

Interface
REQ-001 Parameter IMG_W, default 256: image width in pixels, minimum 3.
REQ-002 Parameter IMG_H, default 256: image height in pixels, minimum 3.
REQ-003 Parameter ADDR_W, default 16: pixel-memory address width, at least clog2(IMG_W*IMG_H); an elaboration-time check SHALL flag violations.
REQ-004 Port clk, input, 1: the single clock; all logic SHALL use its rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port go, input, 1: frame start request, sampled only in IDLE.
REQ-007 Port rdy, output, 1: high while in IDLE.
REQ-008 Port mem_rd, output, 1: pixel-memory read strobe (synchronous RAM, 1-cycle read latency).
REQ-009 Port mem_addr, output, ADDR_W: pixel read address, row-major.
REQ-010 Port coef_idx, output, 4: kernel tap index 0..8, aligned with mem_rd.
REQ-011 Port mac_clr, output, 1: load the accumulator instead of adding to it (first tap of a window).
REQ-012 Port mac_en, output, 1: accumulator enable, aligned with read data.
REQ-013 Port done, output, 1: one-cycle strobe that marks a valid datapath output pixel.
REQ-014 Port out_row, output, 16: output-pixel row, valid with done.
REQ-015 Port out_col, output, 16: output-pixel column, valid with done.
REQ-016 Port frame_done, output, 1: one-cycle strobe that marks the last output pixel of the frame.

Function
REQ-017 The block SHALL implement three states, IDLE, RUN and DRAIN:
- IDLE to RUN: go=1 at a rising edge.
- RUN to DRAIN: after the last tap of the last window is issued.
- DRAIN to IDLE: in the cycle after the final done.
REQ-018 The block SHALL compute valid convolution only, with no padding: output window (r,c) spans r 0..IMG_H-3 and c 0..IMG_W-3, scanned row-major.
REQ-019 Tap addressing:
- Each window SHALL issue 9 consecutive mem_rd cycles, taps t = 0..8, with ky = t/3 and kx = t%3.
- mem_addr SHALL equal (r+ky)*IMG_W + (c+kx).
- coef_idx SHALL equal t.
REQ-020 Address generation SHALL use incremental adders only, with no multiplier.
REQ-021 Window issue SHALL be back-to-back with no bubbles: throughput is 9 cycles per output pixel.
REQ-022 mac_en SHALL be mem_rd delayed by one cycle, and mac_clr SHALL be asserted with mac_en of tap 0.
REQ-023 done SHALL assert one cycle after mac_en of tap 8, with out_row and out_col registered alongside it.
REQ-024 Timing from go sampled at edge k:
- First mem_rd at cycle k+1.
- Done for window n at cycle k+11+9n.
REQ-025 frame_done SHALL coincide with done for the last window.
REQ-026 rdy SHALL rise in the cycle after frame_done.
REQ-027 go in RUN or DRAIN SHALL be ignored; go held high in IDLE after a frame SHALL start a new frame immediately.
REQ-028 mem_rd, mac_en, mac_clr, done and frame_done SHALL never assert in IDLE.

Reset
REQ-029 On rst=1, at any time including mid-frame, the block SHALL immediately enter IDLE with these output values:
- rdy=1.
- mem_rd, mac_en, mac_clr, done and frame_done all 0.
- mem_addr, coef_idx, out_row and out_col all 0.
- All counters cleared.
REQ-030 After rst deasserts, a frame SHALL start only on a fresh go; no partial-frame state SHALL survive reset.

Structure
REQ-031 Shared package/header conv_pkg SHALL hold:
- The state encoding: IDLE, RUN, DRAIN.
- The constants K=3 and TAPS=9.
REQ-032 Sub-module conv_addr_gen SHALL hold the window (r,c) and tap counters and produce mem_addr and coef_idx.
REQ-033 The top-level FSM SHALL hold the state machine, the mac/done alignment pipeline and the frame-end detection.

Verification (IMG_W=5, IMG_H=4: 6 windows, 54 reads)
REQ-034 Reset state: reset, then go at edge k -> mem_addr at k+1..k+9 = 0,1,2,5,6,7,10,11,12; mac_clr at k+2 only; done at k+11 with (0,0).
REQ-035 Full frame: run a full frame -> done at k+11+9n for n=0..5, coordinates (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); frame_done with the 6th done; rdy=1 at k+57.
REQ-036 Last window: last window addresses -> 7,8,9,12,13,14,17,18,19 at k+46..k+54.
REQ-037 Busy go: go toggled every cycle during RUN -> no restart; address sequence unchanged.
REQ-038 Reset mid-frame: rst pulse mid-frame at k+30 -> all strobes 0 at once, rdy=1; a subsequent go restarts at address 0.
REQ-039 Back-to-back frames: go held high -> the second frame's first mem_rd lands one cycle after rdy rises, with addresses identical to frame 1.
